// File: rtl/arb_pkg.sv
// Shared definitions for the four-requester round-robin arbiter:
// requester count, index width, FSM state encoding and a one-hot helper.
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Index to one-hot grant vector.
    function automatic logic [N_REQ-1:0] onehot2(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: returns the first asserted
// request found scanning upward from 'start', wrapping modulo four.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] start,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Walk the four candidates in priority order; the first hit wins.
    always_comb begin
        logic [IDX_W-1:0] cand;
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        valid = 1'b0;
        idx   = start;
        cand  = start;
        for (int i = 0; i < N_REQ; i++) begin
            cand = start + IDX_W'(i);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one resource among four requesters. Grants
// are held until done_i or request withdrawal; on release the next owner is
// chosen in the same edge, starting after the previous owner. All outputs
// are registered. Build option MUX4_ARB_TIMEOUT_EN adds a hold counter that
// forces release after HOLD_MAX cycles and pulses timeout_o.
module mux4_rr_arbiter
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic             done_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] select_o,
    output logic             busy_o,
    output logic             timeout_o
);

    // Parameter sanity check at elaboration.
    if (HOLD_MAX < 2 || HOLD_MAX > 65535 || (2 ** CNT_W) <= HOLD_MAX) begin : g_bad_param
        $error("mux4_rr_arbiter: HOLD_MAX must be 2..65535 and fit in CNT_W bits");
    end

    state_t           state_q;
    logic [IDX_W-1:0] last_q;

    logic [IDX_W-1:0] pick_start;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic             owner_release;
    logic             force_release;
    logic             grant_load;

    // Priority starts after the current owner while granting, after the last owner while idle.
    always_comb begin
        if (state_q == ST_GRANT) begin
            pick_start = select_o + IDX_W'(1);
        end else begin
            pick_start = last_q + IDX_W'(1);
        end
    end

    rr_pick4 u_pick (
        .req   (req_i),
        .start (pick_start),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

`ifdef MUX4_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] hold_cnt_q;

    // Forced release only when the owner is neither finishing nor withdrawing.
    assign force_release = (state_q == ST_GRANT) && (hold_cnt_q == HOLD_LAST)
                           && !done_i && req_i[select_o];

    // Hold counter: cleared on every new grant, counts each granted cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_cnt_q <= '0;
        end else if (grant_load) begin
            hold_cnt_q <= '0;
        end else if (state_q == ST_GRANT) begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
        end
    end
`else
    assign force_release = 1'b0;
`endif

    assign owner_release = (state_q == ST_GRANT)
                           && (done_i || !req_i[select_o] || force_release);
    assign grant_load    = pick_valid && ((state_q == ST_IDLE) || owner_release);

    // Arbiter FSM with registered grant, select, busy and timeout outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            grant_o   <= '0;
            select_o  <= '0;
            busy_o    <= 1'b0;
            timeout_o <= 1'b0;
            last_q    <= IDX_W'(N_REQ - 1);
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            timeout_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_o  <= onehot2(pick_idx);
                        select_o <= pick_idx;
                        busy_o   <= 1'b1;
                        state_q  <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (owner_release) begin
                        last_q    <= select_o;
                        timeout_o <= force_release;
                        if (pick_valid) begin
                            grant_o  <= onehot2(pick_idx);
                            select_o <= pick_idx;
                        end else begin
                            grant_o <= '0;
                            busy_o  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_o <= '0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule
